ir_line_tracker: RTL and testbench

IR_LINE_TRACKER -- requirements
Module: ir_line_tracker

---
 rtl/ir_line_tracker.sv | 222 ++++++++++++++++++++++
 tb/tb_ir_line_tracker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_line_tracker.sv
// rtl/ir_line_tracker.sv - three-channel IR line follower: hysteresis, debounce, steering FSM
// Optional feature: define IR_NODE_COUNT_EN to build the 4-bit wrapping junction counter on node_cnt;
// without it node_cnt is tied to zero.
module ir_line_tracker #(
  parameter logic [11:0] TH_HI      = 12'h900,
  parameter logic [11:0] TH_LO      = 12'h700,
  parameter int          DEBOUNCE   = 3,
  parameter int          LOST_LIMIT = 50000
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        ir_valid,
  input  logic [11:0] ir1,
  input  logic [11:0] ir2,
  input  logic [11:0] ir3,
  output logic        line_l,
  output logic        line_c,
  output logic        line_r,
  output logic [2:0]  cmd,
  output logic        node_det,
  output logic        lost,
  output logic [3:0]  node_cnt
);

  // Motion command encoding seen by the drive stage.
  localparam logic [2:0] CMD_STOP   = 3'd0;
  localparam logic [2:0] CMD_FWD    = 3'd1;
  localparam logic [2:0] CMD_LEFT   = 3'd2;
  localparam logic [2:0] CMD_RIGHT  = 3'd3;
  localparam logic [2:0] CMD_SPIN_L = 3'd4;
  localparam logic [2:0] CMD_SPIN_R = 3'd5;

  // Debounce counter is at least two bits wide and grows with DEBOUNCE.
  localparam int            CW       = (DEBOUNCE < 4) ? 2 : $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  // Last timer value spent in SEARCH before giving up on the line.
  localparam logic [15:0] LOST_LAST = 16'(LOST_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FOLLOW,
    S_SEARCH,
    S_LOST
  } state_t;

  // Channel index 2 = left (ir1), 1 = centre (ir2), 0 = right (ir3), so {l,c,r} reads naturally.
  logic [2:0][11:0]   sample;
  logic [2:0]         raw_q;
  logic [2:0]         raw_d;
  logic [2:0]         deb_q;
  logic [2:0]         deb_d;
  logic [2:0][CW-1:0] cnt_q;
  logic [2:0][CW-1:0] cnt_d;
  logic [2:0]         lcr;

  state_t      state_q;
  logic [2:0]  cmd_q;
  logic [15:0] timer_q;
  logic        side_left_q;
  logic        node_q;
  logic        lost_q;
  logic [2:0]  prev_lcr_q;
  logic        node_hit;

  assign sample = {ir1, ir2, ir3};
  assign lcr    = deb_q;

  // Steering command for a non-empty line pattern.
  function automatic logic [2:0] follow_cmd(input logic [2:0] pat);
    case (pat)
      3'b110, 3'b100: follow_cmd = CMD_LEFT;
      3'b011, 3'b001: follow_cmd = CMD_RIGHT;
      default:        follow_cmd = CMD_FWD;
    endcase
  endfunction

  // Remember which side the line was last seen on; centred patterns keep the old side.
  function automatic logic follow_side(input logic [2:0] pat, input logic cur_left);
    case (pat)
      3'b110, 3'b100: follow_side = 1'b1;
      3'b011, 3'b001: follow_side = 1'b0;
      default:        follow_side = cur_left;
    endcase
  endfunction

  // Hysteresis: strictly above TH_HI sets, strictly below TH_LO clears, anything else holds.
  always_comb begin
    raw_d = raw_q;
    if (ir_valid) begin
      for (int i = 0; i < 3; i++) begin
        if (sample[i] > TH_HI) begin
          raw_d[i] = 1'b1;
        end else if (sample[i] < TH_LO) begin
          raw_d[i] = 1'b0;
        end
      end
    end
  end

  // Debounce: DEBOUNCE consecutive disagreeing strobes flip the bit; one agreeing strobe restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (ir_valid) begin
      for (int i = 0; i < 3; i++) begin
        if (raw_d[i] != deb_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            deb_d[i] = raw_d[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Front-end registers: hysteresis state, debounced flags and their counters.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      raw_q <= '0;
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      raw_q <= raw_d;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  // A junction is the debounced pattern arriving at 111 while actively following.
  assign node_hit = (state_q == S_FOLLOW) && (lcr == 3'b111) && (prev_lcr_q != 3'b111);

  // Steering FSM with registered cmd/node_det/lost; it reacts to the already-debounced pattern.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= CMD_STOP;
      timer_q     <= '0;
      side_left_q <= 1'b0;
      node_q      <= 1'b0;
      lost_q      <= 1'b0;
      prev_lcr_q  <= '0;
    end else begin
      node_q     <= node_hit;
      prev_lcr_q <= lcr;
      case (state_q)
        S_IDLE: begin
          if (ir_valid) begin
            state_q <= S_FOLLOW;
          end
        end
        S_FOLLOW: begin
          if (lcr == 3'b000) begin
            state_q     <= S_SEARCH;
            cmd_q       <= side_left_q ? CMD_SPIN_L : CMD_SPIN_R;
            side_left_q <= 1'b0;
            timer_q     <= '0;
          end else begin
            cmd_q       <= follow_cmd(lcr);
            side_left_q <= follow_side(lcr, side_left_q);
          end
        end
        S_SEARCH: begin
          if (lcr != 3'b000) begin
            state_q     <= S_FOLLOW;
            cmd_q       <= follow_cmd(lcr);
            side_left_q <= follow_side(lcr, side_left_q);
            timer_q     <= '0;
          end else if (timer_q == LOST_LAST) begin
            state_q <= S_LOST;
            cmd_q   <= CMD_STOP;
            lost_q  <= 1'b1;
          end else if (timer_q != 16'hFFFF) begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_LOST: begin
          if (lcr != 3'b000) begin
            state_q     <= S_FOLLOW;
            cmd_q       <= follow_cmd(lcr);
            side_left_q <= follow_side(lcr, side_left_q);
            lost_q      <= 1'b0;
            timer_q     <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cmd_q   <= CMD_STOP;
        end
      endcase
    end
  end

`ifdef IR_NODE_COUNT_EN
  logic [3:0] node_cnt_q;

  // Junction counter advances together with the node_det pulse and wraps past 15.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      node_cnt_q <= '0;
    end else if (node_hit) begin
      node_cnt_q <= node_cnt_q + 4'd1;
    end
  end

  assign node_cnt = node_cnt_q;
`else
  assign node_cnt = 4'd0;
`endif

  assign line_l   = deb_q[2];
  assign line_c   = deb_q[1];
  assign line_r   = deb_q[0];
  assign cmd      = cmd_q;
  assign node_det = node_q;
  assign lost     = lost_q;

endmodule

// File: tb/tb_ir_line_tracker.sv
// tb/tb_ir_line_tracker.sv - randomized and directed bench for ir_line_tracker against a reference model
module tb_ir_line_tracker;

  localparam int          LIMIT = 100;
  localparam int          DEB   = 3;
  localparam logic [11:0] HI    = 12'h900;
  localparam logic [11:0] LO    = 12'h700;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic        ir_valid;
  logic [11:0] ir1;
  logic [11:0] ir2;
  logic [11:0] ir3;
  logic        line_l;
  logic        line_c;
  logic        line_r;
  logic [2:0]  cmd;
  logic        node_det;
  logic        lost;
  logic [3:0]  node_cnt;

  ir_line_tracker #(
    .TH_HI(HI),
    .TH_LO(LO),
    .DEBOUNCE(DEB),
    .LOST_LIMIT(LIMIT)
  ) dut (
    .clk_50(clk_50),
    .rst(rst),
    .ir_valid(ir_valid),
    .ir1(ir1),
    .ir2(ir2),
    .ir3(ir3),
    .line_l(line_l),
    .line_c(line_c),
    .line_r(line_r),
    .cmd(cmd),
    .node_det(node_det),
    .lost(lost),
    .node_cnt(node_cnt)
  );

  always #5 clk_50 = ~clk_50;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. Channels: 0 left, 1 centre, 2 right. Modes: 0 idle, 1 follow, 2 search, 3 lost.
  int m_raw[3];
  int m_deb[3];
  int m_run[3];
  int m_mode, m_cmd, m_left, m_timer, m_prev, m_node, m_lost, m_cnt;
  int node_pulses = 0;
  // Command looked up by pattern value l*4+c*2+r (entry 0 is never used for steering).
  int cmd_tab[8] = '{0, 3, 1, 3, 2, 1, 2, 1};

  task automatic model_follow(input int pat);
    m_cmd = cmd_tab[pat];
    if (m_cmd == 2) m_left = 1;
    else if (m_cmd == 3) m_left = 0;
  endtask

  task automatic model_step(input bit r, input bit v, input int s0, input int s1, input int s2);
    int s[3];
    int pat;
    s = '{s0, s1, s2};
    if (r) begin
      for (int ch = 0; ch < 3; ch++) begin
        m_raw[ch] = 0; m_deb[ch] = 0; m_run[ch] = 0;
      end
      m_mode = 0; m_cmd = 0; m_left = 0; m_timer = 0; m_prev = 0;
      m_node = 0; m_lost = 0; m_cnt = 0;
    end else begin
      pat = m_deb[0] * 4 + m_deb[1] * 2 + m_deb[2];
      m_node = 0;
      if (m_mode == 1 && pat == 7 && m_prev != 7) begin
        m_node = 1;
        m_cnt = (m_cnt + 1) % 16;
      end
      case (m_mode)
        0: if (v) m_mode = 1;
        1: begin
          if (pat == 0) begin
            m_mode = 2; m_cmd = m_left ? 4 : 5; m_left = 0; m_timer = 0;
          end else begin
            model_follow(pat);
          end
        end
        2: begin
          if (pat != 0) begin
            model_follow(pat); m_mode = 1; m_timer = 0;
          end else if (m_timer == LIMIT - 1) begin
            m_mode = 3; m_cmd = 0; m_lost = 1;
          end else begin
            m_timer++;
          end
        end
        default: begin
          if (pat != 0) begin
            model_follow(pat); m_mode = 1; m_lost = 0; m_timer = 0;
          end
        end
      endcase
      m_prev = pat;
      if (v) begin
        for (int ch = 0; ch < 3; ch++) begin
          if (s[ch] > int'(HI)) m_raw[ch] = 1;
          else if (s[ch] < int'(LO)) m_raw[ch] = 0;
          if (m_raw[ch] != m_deb[ch]) begin
            m_run[ch]++;
            if (m_run[ch] == DEB) begin
              m_deb[ch] = m_raw[ch];
              m_run[ch] = 0;
            end
          end else begin
            m_run[ch] = 0;
          end
        end
      end
    end
  endtask

  function automatic int exp_node_cnt(input int n);
`ifdef IR_NODE_COUNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic compare_all();
    check_eq("line_l", int'(line_l), m_deb[0]);
    check_eq("line_c", int'(line_c), m_deb[1]);
    check_eq("line_r", int'(line_r), m_deb[2]);
    check_eq("cmd", int'(cmd), m_cmd);
    check_eq("node_det", int'(node_det), m_node);
    check_eq("lost", int'(lost), m_lost);
    check_eq("node_cnt", int'(node_cnt), exp_node_cnt(m_cnt));
  endtask

  task automatic step(input bit r, input bit v, input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    rst = r; ir_valid = v; ir1 = a; ir2 = b; ir3 = c;
    @(posedge clk_50);
    model_step(r, v, int'(a), int'(b), int'(c));
    #1;
    if (node_det) node_pulses++;
    compare_all();
  endtask

  task automatic strobe(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    step(1'b0, 1'b1, a, b, c);
    step(1'b0, 1'b0, a, b, c);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 12'h100, 12'h100, 12'h100);
  endtask

  function automatic logic [11:0] pick(input int lvl);
    if ($urandom_range(0, 3) == 0) return 12'($urandom_range(0, 4095));
    case (lvl)
      0:       return 12'($urandom_range(0, 12'h6FF));
      1:       return 12'($urandom_range(12'h901, 12'hFFF));
      2:       return 12'($urandom_range(12'h700, 12'h900));
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int lvl[3];
    rst = 1'b1; ir_valid = 1'b0; ir1 = '0; ir2 = '0; ir3 = '0;
    step(1'b1, 1'b1, 12'hA00, 12'hA00, 12'hA00);
    step(1'b1, 1'b0, 12'h100, 12'h100, 12'h100);
    check_eq("reset_cmd", int'(cmd), 0);
    check_eq("reset_line_c", int'(line_c), 0);

    // Centre line acquired after three strobes, FWD one cycle later.
    repeat (2) strobe(12'h100, 12'hA00, 12'h100);
    step(1'b0, 1'b1, 12'h100, 12'hA00, 12'h100);
    check_eq("req027_line_c", int'(line_c), 1);
    step(1'b0, 1'b0, 12'h100, 12'hA00, 12'h100);
    check_eq("req027_cmd_fwd", int'(cmd), 1);

    // Alternating glitches on the centre channel are rejected.
    for (int i = 0; i < 10; i++) strobe(12'h100, (i % 2 == 1) ? 12'hA00 : 12'h100, 12'h100);
    check_eq("req028_line_c", int'(line_c), 1);
    check_eq("req028_cmd", int'(cmd), 1);

    // Between thresholds holds; just below TH_LO clears after three strobes.
    repeat (3) strobe(12'h100, 12'h800, 12'h100);
    check_eq("req029_hold", int'(line_c), 1);
    repeat (3) strobe(12'h100, 12'h6FF, 12'h100);
    check_eq("req029_clear", int'(line_c), 0);

    // Go LEFT, lose the line, spin left, time out to LOST, recover to LEFT.
    repeat (3) strobe(12'hA00, 12'hA00, 12'h100);
    check_eq("req030_left", int'(cmd), 2);
    repeat (3) strobe(12'h100, 12'h100, 12'h100);
    k = 0;
    while (cmd != 3'd4 && k < 10) begin idle(1); k++; end
    check_eq("req030_spin_l", int'(cmd), 4);
    k = 0;
    while (!lost && k < 200) begin idle(1); k++; end
    check_eq("req030_lost_delay", k, LIMIT);
    check_eq("req030_stop", int'(cmd), 0);
    repeat (3) strobe(12'hA00, 12'h100, 12'h100);
    check_eq("req030_recover_left", int'(cmd), 2);
    check_eq("req030_lost_clear", int'(lost), 0);

    // One junction pulse for a held 111, then 15 more to wrap the counter.
    repeat (3) strobe(12'h100, 12'hA00, 12'h100);
    node_pulses = 0;
    repeat (10) strobe(12'hA00, 12'hA00, 12'hA00);
    check_eq("req031_pulses", node_pulses, 1);
    check_eq("req031_cnt1", int'(node_cnt), exp_node_cnt(1));
    repeat (15) begin
      repeat (3) strobe(12'h100, 12'hA00, 12'h100);
      repeat (3) strobe(12'hA00, 12'hA00, 12'hA00);
    end
    check_eq("req031_pulses16", node_pulses, 16);
    check_eq("req031_wrap", int'(node_cnt), 0);

    // Reset in SEARCH with the timer at 40.
    repeat (3) strobe(12'h100, 12'h100, 12'h100);
    k = 0;
    while (cmd < 3'd4 && k < 10) begin idle(1); k++; end
    idle(40);
    step(1'b1, 1'b1, 12'hA00, 12'hA00, 12'hA00);
    check_eq("req032_cmd", int'(cmd), 0);
    check_eq("req032_lost", int'(lost), 0);
    check_eq("req032_line_c", int'(line_c), 0);
    // Fresh run from IDLE must take the full timeout, proving the timer was cleared.
    strobe(12'h100, 12'h100, 12'h100);
    check_eq("req032_spin_r", int'(cmd), 5);
    k = 0;
    while (!lost && k < 200) begin idle(1); k++; end
    check_eq("req032_lost_delay", k, LIMIT);

    // Randomized segments with per-channel bias, occasional resets and long dark gaps.
    for (int seg = 0; seg < 200; seg++) begin
      for (int ch = 0; ch < 3; ch++) lvl[ch] = $urandom_range(0, 3);
      if (seg % 25 == 0) idle(120);
      for (int t = 0; t < 24; t++) begin
        step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, pick(lvl[0]), pick(lvl[1]), pick(lvl[2]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
